// File: rtl/ysyx22041405_lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit controller: access-size masks,
// FSM state encoding, error codes and small size/alignment helpers.
package ysyx22041405_lsu_ctrl_pkg;

  localparam logic [7:0] MASK_BYTE = 8'h01;
  localparam logic [7:0] MASK_HALF = 8'h03;
  localparam logic [7:0] MASK_WORD = 8'h0F;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Any encoding other than BYTE/HALF behaves as WORD.
  function automatic logic is_misaligned(input logic [7:0] mask, input logic [1:0] off);
    if (mask == MASK_BYTE) return 1'b0;
    if (mask == MASK_HALF) return off[0];
    return off != 2'b00;
  endfunction

  function automatic logic [3:0] size_strb(input logic [7:0] mask);
    case (mask)
      MASK_BYTE: return 4'b0001;
      MASK_HALF: return 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ysyx22041405_lsu_ctrl_ld_align.sv
// Load data alignment: shifts the returned word down to the accessed byte lane,
// truncates to the access size and sign/zero-extends.
module ysyx22041405_ld_align
  import ysyx22041405_lsu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       offset,
  input  logic [7:0]       mask,
  input  logic             ld_unsigned,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (mask)
      MASK_BYTE: data = {{(WIDTH-8){~ld_unsigned & shifted[7]}}, shifted[7:0]};
      MASK_HALF: data = {{(WIDTH-16){~ld_unsigned & shifted[15]}}, shifted[15:0]};
      default:   data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx22041405_lsu_ctrl.sv
// Load/store unit controller: accepts one EXU access at a time, issues it to the
// data memory, waits for the response under a watchdog and writes the result back.
module ysyx22041405_lsu_ctrl
  import ysyx22041405_lsu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ls_valid,
  output logic             ls_ready,
  input  logic             ls_wen,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  input  logic [7:0]       ls_mask,
  input  logic             ls_unsigned,
  input  logic [4:0]       ls_rd,
  output logic             dm_req_valid,
  input  logic             dm_req_ready,
  output logic [WIDTH-1:0] dm_req_addr,
  output logic             dm_req_wen,
  output logic [WIDTH-1:0] dm_req_wdata,
  output logic [3:0]       dm_req_wstrb,
  input  logic             dm_resp_valid,
  input  logic [WIDTH-1:0] dm_resp_rdata,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_wen,
  output logic             ls_err,
  output logic [1:0]       ls_err_code
);

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [7:0]       wdog_q, wdog_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             wen_q, wen_d;
  logic             uns_q, uns_d;
  logic [1:0]       off_q, off_d;
  logic [7:0]       mask_q, mask_d;
  logic [4:0]       rd_q, rd_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [WIDTH-1:0] ld_data_c;

  ysyx22041405_ld_align #(.WIDTH(WIDTH)) u_ld_align (
    .rdata       (dm_resp_rdata),
    .offset      (off_q),
    .mask        (mask_q),
    .ld_unsigned (uns_q),
    .data        (ld_data_c)
  );

  // Next-state and request/writeback payload computation.
  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wen_d      = wen_q;
    uns_d      = uns_q;
    off_d      = off_q;
    mask_d     = mask_q;
    rd_d       = rd_q;
    data_d     = data_q;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (ls_valid) begin
          addr_d  = {ls_addr[WIDTH-1:2], 2'b00};
          wdata_d = WIDTH'(ls_wdata << {ls_addr[1:0], 3'b000});
          wstrb_d = ls_wen ? 4'(size_strb(ls_mask) << ls_addr[1:0]) : 4'b0000;
          wen_d   = ls_wen;
          uns_d   = ls_unsigned;
          off_d   = ls_addr[1:0];
          mask_d  = ls_mask;
          rd_d    = ls_rd;
          data_d  = '0;
          if (is_misaligned(ls_mask, ls_addr[1:0])) begin
            err_d      = 1'b1;
            err_code_d = ERR_MISALIGN;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // A response arriving alongside the handshake belongs to no request yet.
        if (dm_req_ready) begin
          state_d = ST_WAIT;
          wdog_d  = '0;
        end
      end
      ST_WAIT: begin
        if (dm_resp_valid) begin
          data_d  = wen_q ? '0 : ld_data_c;
          state_d = ST_DONE;
        end else if (wdog_q == TMO_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          wdog_d     = '0;
          state_d    = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wdog_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wen_q      <= 1'b0;
      uns_q      <= 1'b0;
      off_q      <= '0;
      mask_q     <= '0;
      rd_q       <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wen_q      <= wen_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      mask_q     <= mask_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Outputs decode the registered state; payloads read as zero when not presented.
  assign ls_ready     = (state_q == ST_IDLE);
  assign dm_req_valid = (state_q == ST_REQ);
  assign dm_req_addr  = dm_req_valid ? addr_q : '0;
  assign dm_req_wen   = dm_req_valid & wen_q;
  assign dm_req_wdata = dm_req_valid ? wdata_q : '0;
  assign dm_req_wstrb = dm_req_valid ? wstrb_q : 4'b0000;
  assign wb_valid     = (state_q == ST_DONE);
  assign wb_rd        = wb_valid ? rd_q : 5'd0;
  assign wb_data      = wb_valid ? data_q : '0;
  assign wb_wen       = wb_valid & ~wen_q;
  assign ls_err       = err_q;
  assign ls_err_code  = err_code_q;

endmodule

// File: tb/tb_ysyx22041405_lsu_ctrl.sv
// Bench for ysyx22041405_lsu_ctrl: directed vector table, reset-in-flight sequence
// and randomized accesses checked against an arithmetic reference model.
module tb_ysyx22041405_lsu_ctrl;
  import ysyx22041405_lsu_ctrl_pkg::*;

  logic        clk, rst_n;
  logic        ls_valid, ls_ready, ls_wen, ls_unsigned;
  logic [31:0] ls_addr, ls_wdata;
  logic [7:0]  ls_mask;
  logic [4:0]  ls_rd;
  logic        dm_req_valid, dm_req_ready, dm_req_wen, dm_resp_valid;
  logic [31:0] dm_req_addr, dm_req_wdata, dm_resp_rdata;
  logic [3:0]  dm_req_wstrb;
  logic        wb_valid, wb_wen, ls_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  ls_err_code;

  int n_checks = 0;
  int n_err    = 0;

  ysyx22041405_lsu_ctrl #(.WIDTH(32), .TMO_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_wen(ls_wen), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_mask(ls_mask), .ls_unsigned(ls_unsigned), .ls_rd(ls_rd),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
    .dm_req_wen(dm_req_wen), .dm_req_wdata(dm_req_wdata), .dm_req_wstrb(dm_req_wstrb),
    .dm_resp_valid(dm_resp_valid), .dm_resp_rdata(dm_resp_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_wen(wb_wen),
    .ls_err(ls_err), .ls_err_code(ls_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  mask;
    logic        uns;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          req_lat;
    int          resp_lat;
    logic        noise;
    logic        exp_err;
    logic [1:0]  exp_code;
    int          exp_lat;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wb;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [7:0] mask, input logic uns, input logic [4:0] rd,
                              input logic [31:0] rdata, input int req_lat, input int resp_lat,
                              input logic noise, input logic exp_err, input logic [1:0] exp_code,
                              input int exp_lat, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                              input logic [31:0] exp_wb);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wdata; v.mask = mask; v.uns = uns; v.rd = rd;
    v.rdata = rdata; v.req_lat = req_lat; v.resp_lat = resp_lat; v.noise = noise;
    v.exp_err = exp_err; v.exp_code = exp_code; v.exp_lat = exp_lat; v.exp_addr = exp_addr;
    v.exp_wdata = exp_wdata; v.exp_wstrb = exp_wstrb; v.exp_wb = exp_wb;
    return v;
  endfunction

  // Reference model: access size in bytes, alignment by modulo, extension by plain masks.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          sz, off;
    logic        misal, tmo;
    logic [31:0] val;
    r     = v;
    sz    = (v.mask == 8'h01) ? 1 : (v.mask == 8'h03) ? 2 : 4;
    off   = int'(v.addr[1:0]);
    misal = (off % sz) != 0;
    tmo   = !misal && (v.resp_lat >= 255);
    r.exp_err   = misal || tmo;
    r.exp_code  = misal ? 2'd1 : (tmo ? 2'd2 : 2'd0);
    r.exp_lat   = misal ? 1 : (tmo ? v.req_lat + 257 : v.req_lat + 3 + v.resp_lat);
    r.exp_addr  = v.addr & 32'hFFFF_FFFC;
    r.exp_wdata = v.wdata << (8 * off);
    r.exp_wstrb = v.wen ? 4'(((1 << sz) - 1) << off) : 4'b0000;
    val = v.rdata >> (8 * off);
    if (sz == 1) begin
      val = val & 32'h0000_00FF;
      if (!v.uns && val[7]) val = val | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      val = val & 32'h0000_FFFF;
      if (!v.uns && val[15]) val = val | 32'hFFFF_0000;
    end
    r.exp_wb = v.wen ? 32'h0 : val;
    return r;
  endfunction

  // Drives one access, plays the memory side cycle by cycle and checks the outcome.
  task automatic run_and_check(input vec_t v, input int id);
    logic        seen_req, seen_wb, seen_err, first, unstable, hs, exp_req;
    logic [1:0]  code;
    logic [31:0] r_addr, r_wdata, wbd;
    logic [3:0]  r_wstrb;
    logic        r_wen, wbw;
    logic [4:0]  wbr;
    int          cyc, reqcnt, k;
    string       t;
    seen_req = 0; seen_wb = 0; seen_err = 0; first = 0; unstable = 0; hs = 0;
    code = 0; r_addr = 0; r_wdata = 0; wbd = 0; r_wstrb = 0; r_wen = 0; wbw = 0; wbr = 0;
    reqcnt = 0; k = 0;
    t = $sformatf("op%0d", id);

    ls_valid = 1; ls_wen = v.wen; ls_addr = v.addr; ls_wdata = v.wdata;
    ls_mask = v.mask; ls_unsigned = v.uns; ls_rd = v.rd;
    tick();
    ls_valid = 0;
    cyc = 1;
    while (cyc < 400) begin
      if (dm_req_valid) seen_req = 1;
      if (wb_valid) begin
        seen_wb = 1; wbd = wb_data; wbw = wb_wen; wbr = wb_rd;
        break;
      end
      if (ls_err) begin
        seen_err = 1; code = ls_err_code;
        break;
      end
      dm_req_ready = 0; dm_resp_valid = 0; dm_resp_rdata = v.rdata ^ 32'hDEAD_BEEF;
      if (dm_req_valid) begin
        if (!first) begin
          first = 1; r_addr = dm_req_addr; r_wdata = dm_req_wdata;
          r_wstrb = dm_req_wstrb; r_wen = dm_req_wen;
        end else if ({dm_req_addr, dm_req_wdata, dm_req_wstrb, dm_req_wen} !==
                     {r_addr, r_wdata, r_wstrb, r_wen}) begin
          unstable = 1;
        end
        if (reqcnt >= v.req_lat) begin
          dm_req_ready = 1; hs = 1;
        end
        if (v.noise) dm_resp_valid = 1;
        reqcnt++;
      end else if (hs) begin
        if (k == v.resp_lat) begin
          dm_resp_valid = 1; dm_resp_rdata = v.rdata;
        end
        k++;
      end
      tick();
      cyc++;
    end
    dm_req_ready = 0; dm_resp_valid = 0;
    if (cyc >= 400) begin
      n_checks++; n_err++;
      $display("FAIL %s.wait_bound: no wb_valid/ls_err within 400 cycles", t);
    end

    exp_req = !(v.exp_err && v.exp_code == 2'd1);
    chk({t, ".err"}, 32'(seen_err), 32'(v.exp_err));
    chk({t, ".wb_valid"}, 32'(seen_wb), 32'(!v.exp_err));
    chk({t, ".latency"}, 32'(cyc), 32'(v.exp_lat));
    chk({t, ".req_seen"}, 32'(seen_req), 32'(exp_req));
    if (v.exp_err) chk({t, ".err_code"}, 32'(code), 32'(v.exp_code));
    if (exp_req) begin
      chk({t, ".req_addr"}, r_addr, v.exp_addr);
      chk({t, ".req_wstrb"}, 32'(r_wstrb), 32'(v.exp_wstrb));
      chk({t, ".req_wen"}, 32'(r_wen), 32'(v.wen));
      chk({t, ".req_stable"}, 32'(unstable), 32'd0);
      if (v.wen) chk({t, ".req_wdata"}, r_wdata, v.exp_wdata);
    end
    if (!v.exp_err) begin
      chk({t, ".wb_data"}, wbd, v.exp_wb);
      chk({t, ".wb_wen"}, 32'(wbw), 32'(!v.wen));
      chk({t, ".wb_rd"}, 32'(wbr), 32'(v.rd));
    end
    tick();
    chk({t, ".pulse_end"}, 32'({wb_valid, ls_err}), 32'd0);
    chk({t, ".ready_after"}, 32'(ls_ready), 32'd1);
  endtask

  vec_t tbl[13];
  vec_t rv;

  initial begin
    rst_n = 0; ls_valid = 0; ls_wen = 0; ls_addr = 0; ls_wdata = 0; ls_mask = 0;
    ls_unsigned = 0; ls_rd = 0; dm_req_ready = 0; dm_resp_valid = 0; dm_resp_rdata = 0;

    tick();
    tick();
    chk("reset.ls_ready", 32'(ls_ready), 32'd1);
    chk("reset.outputs", 32'({dm_req_valid, wb_valid, wb_wen, ls_err, ls_err_code}), 32'd0);
    chk("reset.wb_data", wb_data, 32'd0);
    rst_n = 1;
    tick();

    tbl[0]  = mk(0, 32'h8000_0003, 32'h0, MASK_BYTE, 0, 5'd1, 32'h80FF_1234, 0, 0, 0,
                 0, 2'd0, 3, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80);
    tbl[1]  = mk(1, 32'h8000_0002, 32'h0000_ABCD, MASK_HALF, 0, 5'd2, 32'h0, 0, 0, 0,
                 0, 2'd0, 3, 32'h8000_0000, 32'hABCD_0000, 4'b1100, 32'h0);
    tbl[2]  = mk(0, 32'h8000_0001, 32'h0, MASK_WORD, 0, 5'd3, 32'h1111_1111, 0, 0, 0,
                 1, 2'd1, 1, 32'h0, 32'h0, 4'b0000, 32'h0);
    tbl[3]  = mk(0, 32'h8000_0000, 32'h0, MASK_HALF, 1, 5'd4, 32'h1234_F00F, 5, 0, 0,
                 0, 2'd0, 8, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_F00F);
    tbl[4]  = mk(0, 32'h8000_0040, 32'h0, MASK_WORD, 0, 5'd5, 32'h0, 0, 255, 0,
                 1, 2'd2, 257, 32'h8000_0040, 32'h0, 4'b0000, 32'h0);
    tbl[5]  = mk(0, 32'h8000_0002, 32'h0, MASK_HALF, 0, 5'd6, 32'h8001_0000, 1, 2, 1,
                 0, 2'd0, 6, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_8001);
    tbl[6]  = mk(0, 32'h0000_0001, 32'h0, MASK_BYTE, 1, 5'd7, 32'h0000_FF00, 0, 1, 0,
                 0, 2'd0, 4, 32'h0000_0000, 32'h0, 4'b0000, 32'h0000_00FF);
    tbl[7]  = mk(1, 32'h0000_0101, 32'h0000_0012, MASK_BYTE, 0, 5'd8, 32'h0, 0, 0, 1,
                 0, 2'd0, 3, 32'h0000_0100, 32'h0000_1200, 4'b0010, 32'h0);
    tbl[8]  = mk(1, 32'h0000_0100, 32'hCAFE_BABE, MASK_WORD, 0, 5'd9, 32'h0, 2, 1, 0,
                 0, 2'd0, 6, 32'h0000_0100, 32'hCAFE_BABE, 4'b1111, 32'h0);
    tbl[9]  = mk(0, 32'h0000_0004, 32'h0, 8'h07, 0, 5'd10, 32'h8765_4321, 0, 0, 0,
                 0, 2'd0, 3, 32'h0000_0004, 32'h0, 4'b0000, 32'h8765_4321);
    tbl[10] = mk(0, 32'h0000_0006, 32'h0, 8'h07, 0, 5'd11, 32'h0, 0, 0, 0,
                 1, 2'd1, 1, 32'h0, 32'h0, 4'b0000, 32'h0);
    tbl[11] = mk(1, 32'h0000_0003, 32'h0000_1234, MASK_HALF, 0, 5'd12, 32'h0, 0, 0, 0,
                 1, 2'd1, 1, 32'h0, 32'h0, 4'b0000, 32'h0);
    tbl[12] = mk(0, 32'h0000_0002, 32'h0, MASK_BYTE, 0, 5'd13, 32'h00F1_0000, 0, 0, 1,
                 0, 2'd0, 3, 32'h0000_0000, 32'h0, 4'b0000, 32'hFFFF_FFF1);

    for (int i = 0; i < 13; i++) run_and_check(tbl[i], i);

    // Reset while waiting for a response; the late response must be dropped.
    ls_valid = 1; ls_wen = 0; ls_addr = 32'h8000_0010; ls_mask = MASK_WORD; ls_rd = 5'd20;
    tick();
    ls_valid = 0; dm_req_ready = 1;
    tick();
    dm_req_ready = 0;
    tick();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("rst_wait.ls_ready", 32'(ls_ready), 32'd1);
    dm_resp_valid = 1; dm_resp_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_wait.quiet%0d", i), 32'({wb_valid, ls_err, dm_req_valid}), 32'd0);
    end
    dm_resp_valid = 0;
    chk("rst_wait.ready_end", 32'(ls_ready), 32'd1);
    tick();

    for (int i = 0; i < 60; i++) begin
      rv.wen      = 1'($urandom);
      rv.addr     = $urandom;
      rv.wdata    = $urandom;
      case ($urandom_range(0, 4))
        0:       rv.mask = MASK_BYTE;
        1:       rv.mask = MASK_HALF;
        2:       rv.mask = 8'($urandom);
        default: rv.mask = MASK_WORD;
      endcase
      rv.uns      = 1'($urandom);
      rv.rd       = 5'($urandom);
      rv.rdata    = $urandom;
      rv.req_lat  = int'($urandom_range(0, 3));
      rv.resp_lat = int'($urandom_range(0, 3));
      rv.noise    = 1'($urandom);
      rv = model(rv);
      run_and_check(rv, 100 + i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
